// File: rtl/rob_queue_if.sv
// ---------------------------------------------------------------------------
// rob_queue_if
// Bundles the reorder-buffer traffic: dispatch enqueue, writeback completion,
// in-order commit and the occupancy count.
//   master : dispatch/writeback side (drives enq_* payload and wb_*, observes
//            enq_ready, enq_robidx, commit_* and count)
//   slave  : the reorder buffer itself
// ---------------------------------------------------------------------------
interface rob_queue_if #(
    parameter int DEPTH    = 16,
    parameter int WB_PORTS = 2,
    parameter int COMMIT_W = 2,
    parameter int PC_W     = 64,
    parameter int LREG_W   = 5,
    parameter int PREG_W   = 6
);
    localparam int IDX_W = $clog2(DEPTH);

    logic                         enq_valid;
    logic                         enq_ready;
    logic [PC_W-1:0]              enq_pc;
    logic [31:0]                  enq_instr;
    logic [LREG_W-1:0]            enq_lrd;
    logic [PREG_W-1:0]            enq_prd;
    logic [PREG_W-1:0]            enq_old_prd;
    logic [IDX_W-1:0]             enq_robidx;
    logic [WB_PORTS-1:0]          wb_valid;
    logic [WB_PORTS*IDX_W-1:0]    wb_robidx;
    logic [COMMIT_W-1:0]          commit_valid;
    logic [COMMIT_W*PC_W-1:0]     commit_pc;
    logic [COMMIT_W*32-1:0]       commit_instr;
    logic [COMMIT_W*LREG_W-1:0]   commit_lrd;
    logic [COMMIT_W*PREG_W-1:0]   commit_prd;
    logic [COMMIT_W*PREG_W-1:0]   commit_old_prd;
    logic [IDX_W:0]               count;

    modport master (
        output enq_valid, enq_pc, enq_instr, enq_lrd, enq_prd, enq_old_prd,
               wb_valid, wb_robidx,
        input  enq_ready, enq_robidx, commit_valid, commit_pc, commit_instr,
               commit_lrd, commit_prd, commit_old_prd, count
    );

    modport slave (
        input  enq_valid, enq_pc, enq_instr, enq_lrd, enq_prd, enq_old_prd,
               wb_valid, wb_robidx,
        output enq_ready, enq_robidx, commit_valid, commit_pc, commit_instr,
               commit_lrd, commit_prd, commit_old_prd, count
    );
endinterface

// File: rtl/rob_queue.sv
// ---------------------------------------------------------------------------
// rob_queue
// Reorder buffer organised as a circular queue of DEPTH entries. Dispatch
// allocates one entry per cycle at the tail, writeback ports mark entries
// complete, and up to COMMIT_W contiguous completed entries retire from the
// head each cycle, strictly in program order.
// Ports:
//   clock    : clock
//   reset_n  : asynchronous active-low reset, discards all entries
//   flush    : (only with ROB_FLUSH_EN) drops every entry at the next edge
//   rob      : rob_queue_if.slave (enqueue, writeback, commit, count)
// Optional feature macro: ROB_FLUSH_EN (adds the flush port).
// Head/tail carry one extra wrap bit so full and empty are distinguishable.
// ---------------------------------------------------------------------------
module rob_queue #(
    parameter int DEPTH    = 16,
    parameter int WB_PORTS = 2,
    parameter int COMMIT_W = 2,
    parameter int PC_W     = 64,
    parameter int LREG_W   = 5,
    parameter int PREG_W   = 6
) (
    input  logic       clock,
    input  logic       reset_n,
`ifdef ROB_FLUSH_EN
    input  logic       flush,
`endif
    rob_queue_if.slave rob
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W:0]     head_r;
    logic [IDX_W:0]     tail_r;
    logic [IDX_W:0]     count_s;
    logic [IDX_W-1:0]   head_idx_s;
    logic [IDX_W-1:0]   tail_idx_s;
    logic               flush_s;
    logic               enq_fire_s;
    logic [COMMIT_W-1:0] commit_valid_s;
    logic [IDX_W:0]     commit_num_s;
    logic [IDX_W-1:0]   slot_idx_s [COMMIT_W];

    logic               valid_r    [DEPTH];
    logic               complete_r [DEPTH];
    logic [PC_W-1:0]    pc_r       [DEPTH];
    logic [31:0]        instr_r    [DEPTH];
    logic [LREG_W-1:0]  lrd_r      [DEPTH];
    logic [PREG_W-1:0]  prd_r      [DEPTH];
    logic [PREG_W-1:0]  old_prd_r  [DEPTH];

`ifdef ROB_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    assign count_s        = tail_r - head_r;
    assign head_idx_s     = head_r[IDX_W-1:0];
    assign tail_idx_s     = tail_r[IDX_W-1:0];
    // Ready looks only at registered occupancy; a same-cycle commit does not free a slot early.
    assign rob.enq_ready  = (count_s != (IDX_W+1)'(DEPTH));
    assign rob.enq_robidx = tail_idx_s;
    assign rob.count      = count_s;
    assign enq_fire_s     = rob.enq_valid & rob.enq_ready & ~flush_s;

    // Commit selection: walk from the head and stop at the first entry not ready to retire.
    always_comb begin
        logic chain_v;
        chain_v            = 1'b1;
        commit_valid_s     = '0;
        commit_num_s       = '0;
        rob.commit_pc      = '0;
        rob.commit_instr   = '0;
        rob.commit_lrd     = '0;
        rob.commit_prd     = '0;
        rob.commit_old_prd = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            slot_idx_s[i] = head_idx_s + IDX_W'(i);
            chain_v = chain_v & valid_r[slot_idx_s[i]] & complete_r[slot_idx_s[i]]
                      & ((IDX_W+1)'(i) < count_s) & ~flush_s;
            commit_valid_s[i] = chain_v;
            commit_num_s      = commit_num_s + (IDX_W+1)'(chain_v);
            rob.commit_pc[i*PC_W +: PC_W]           = pc_r[slot_idx_s[i]];
            rob.commit_instr[i*32 +: 32]            = instr_r[slot_idx_s[i]];
            rob.commit_lrd[i*LREG_W +: LREG_W]      = lrd_r[slot_idx_s[i]];
            rob.commit_prd[i*PREG_W +: PREG_W]      = prd_r[slot_idx_s[i]];
            rob.commit_old_prd[i*PREG_W +: PREG_W]  = old_prd_r[slot_idx_s[i]];
        end
        rob.commit_valid = commit_valid_s;
    end

    // Queue state: pointers, per-entry status bits and payload storage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_r <= '0;
            tail_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i]    <= 1'b0;
                complete_r[i] <= 1'b0;
                pc_r[i]       <= '0;
                instr_r[i]    <= '0;
                lrd_r[i]      <= '0;
                prd_r[i]      <= '0;
                old_prd_r[i]  <= '0;
            end
        end else if (flush_s) begin
            head_r <= '0;
            tail_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i]    <= 1'b0;
                complete_r[i] <= 1'b0;
            end
        end else begin
            // The entry being enqueued is still invalid here, so a writeback
            // aimed at it this cycle is dropped by the valid check.
            for (int p = 0; p < WB_PORTS; p++) begin
                if (rob.wb_valid[p] && valid_r[rob.wb_robidx[p*IDX_W +: IDX_W]]) begin
                    complete_r[rob.wb_robidx[p*IDX_W +: IDX_W]] <= 1'b1;
                end
            end
            // Retirement clears after writeback so a late duplicate completion cannot revive a slot.
            for (int i = 0; i < COMMIT_W; i++) begin
                if (commit_valid_s[i]) begin
                    valid_r[slot_idx_s[i]]    <= 1'b0;
                    complete_r[slot_idx_s[i]] <= 1'b0;
                end
            end
            if (enq_fire_s) begin
                valid_r[tail_idx_s]    <= 1'b1;
                complete_r[tail_idx_s] <= 1'b0;
                pc_r[tail_idx_s]       <= rob.enq_pc;
                instr_r[tail_idx_s]    <= rob.enq_instr;
                lrd_r[tail_idx_s]      <= rob.enq_lrd;
                prd_r[tail_idx_s]      <= rob.enq_prd;
                old_prd_r[tail_idx_s]  <= rob.enq_old_prd;
                tail_r                 <= tail_r + (IDX_W+1)'(1);
            end
            head_r <= head_r + commit_num_s;
        end
    end
endmodule

// File: tb/tb_rob_queue.sv
// ---------------------------------------------------------------------------
// tb_rob_queue
// Directed scenarios followed by randomized traffic. A behavioural model
// (occupancy count, head position and per-slot completion flags) predicts
// ready, count, allocation index and the retiring entries every cycle.
// ---------------------------------------------------------------------------
module tb_rob_queue;
    localparam int DEPTH    = 16;
    localparam int WB_PORTS = 2;
    localparam int COMMIT_W = 2;
    localparam int PC_W     = 64;
    localparam int LREG_W   = 5;
    localparam int PREG_W   = 6;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
`ifdef ROB_FLUSH_EN
    logic flush   = 1'b0;
`endif

    always #5 clock = ~clock;

    rob_queue_if #(.DEPTH(DEPTH), .WB_PORTS(WB_PORTS), .COMMIT_W(COMMIT_W),
                   .PC_W(PC_W), .LREG_W(LREG_W), .PREG_W(PREG_W)) rob ();

    rob_queue #(.DEPTH(DEPTH), .WB_PORTS(WB_PORTS), .COMMIT_W(COMMIT_W),
                .PC_W(PC_W), .LREG_W(LREG_W), .PREG_W(PREG_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
`ifdef ROB_FLUSH_EN
        .flush   (flush),
`endif
        .rob     (rob)
    );

    // Reference model
    bit                m_valid [DEPTH];
    bit                m_comp  [DEPTH];
    logic [PC_W-1:0]   m_pc    [DEPTH];
    logic [31:0]       m_instr [DEPTH];
    logic [LREG_W-1:0] m_lrd   [DEPTH];
    logic [PREG_W-1:0] m_prd   [DEPTH];
    logic [PREG_W-1:0] m_old   [DEPTH];
    int m_head;
    int m_count;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_comp[i]  = 1'b0;
        end
        m_head  = 0;
        m_count = 0;
    endfunction

    // Number of oldest entries that are complete, up to the commit width.
    function automatic int m_ncommit(input bit fl);
        int n = 0;
        if (fl) return 0;
        while (n < COMMIT_W && n < m_count && m_comp[(m_head + n) % DEPTH]) n++;
        return n;
    endfunction

    task automatic compare_all(input bit fl);
        int n;
        int s;
        logic [COMMIT_W-1:0] exp_cv;
        n      = m_ncommit(fl);
        exp_cv = '0;
        for (int i = 0; i < n; i++) exp_cv[i] = 1'b1;
        check("enq_ready", rob.enq_ready, (m_count != DEPTH));
        check("count", rob.count, m_count);
        check("enq_robidx", rob.enq_robidx, (m_head + m_count) % DEPTH);
        check("commit_valid", rob.commit_valid, exp_cv);
        for (int i = 0; i < n; i++) begin
            s = (m_head + i) % DEPTH;
            check("commit_pc", rob.commit_pc[i*PC_W +: PC_W], m_pc[s]);
            check("commit_instr", rob.commit_instr[i*32 +: 32], m_instr[s]);
            check("commit_lrd", rob.commit_lrd[i*LREG_W +: LREG_W], m_lrd[s]);
            check("commit_prd", rob.commit_prd[i*PREG_W +: PREG_W], m_prd[s]);
            check("commit_old_prd", rob.commit_old_prd[i*PREG_W +: PREG_W], m_old[s]);
        end
    endtask

    function automatic void model_step(input bit ev, input bit [1:0] wv,
                                       input int w0, input int w1, input bit fl);
        int n;
        int tail;
        bit fire;
        if (fl) begin
            model_clear();
            return;
        end
        n    = m_ncommit(1'b0);
        tail = (m_head + m_count) % DEPTH;
        fire = ev && (m_count != DEPTH);
        if (wv[0] && m_valid[w0]) m_comp[w0] = 1'b1;
        if (wv[1] && m_valid[w1]) m_comp[w1] = 1'b1;
        for (int i = 0; i < n; i++) begin
            m_valid[(m_head + i) % DEPTH] = 1'b0;
            m_comp[(m_head + i) % DEPTH]  = 1'b0;
        end
        if (fire) begin
            m_valid[tail] = 1'b1;
            m_comp[tail]  = 1'b0;
            m_pc[tail]    = rob.enq_pc;
            m_instr[tail] = rob.enq_instr;
            m_lrd[tail]   = rob.enq_lrd;
            m_prd[tail]   = rob.enq_prd;
            m_old[tail]   = rob.enq_old_prd;
        end
        m_head  = (m_head + n) % DEPTH;
        m_count = m_count - n + int'(fire);
    endfunction

    // One clock: drive at posedge+1, check at negedge, return at next posedge+1.
    task automatic cycle(input bit ev, input bit [1:0] wv, input int w0, input int w1,
                         input bit fl, input bit rnd);
        rob.enq_valid = ev;
        if (rnd) begin
            rob.enq_pc      = {$urandom, $urandom};
            rob.enq_instr   = $urandom;
            rob.enq_lrd     = LREG_W'($urandom);
            rob.enq_prd     = PREG_W'($urandom);
            rob.enq_old_prd = PREG_W'($urandom);
        end
        rob.wb_valid  = wv;
        rob.wb_robidx = {4'(w1), 4'(w0)};
`ifdef ROB_FLUSH_EN
        flush = fl;
`endif
        @(negedge clock);
        compare_all(fl);
        model_step(ev, wv, w0, w1, fl);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rob.enq_valid = 1'b0;
        rob.wb_valid  = '0;
        rob.wb_robidx = '0;
`ifdef ROB_FLUSH_EN
        flush = 1'b0;
`endif
        reset_n = 1'b0;
        model_clear();
        #2;
        check("rst_count", rob.count, 64'd0);
        check("rst_ready", rob.enq_ready, 64'd1);
        check("rst_cv", rob.commit_valid, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        rob.enq_pc = '0; rob.enq_instr = '0; rob.enq_lrd = '0;
        rob.enq_prd = '0; rob.enq_old_prd = '0;
        @(posedge clock);
        #1;
        do_reset();

        // Single instruction: allocate, complete, retire.
        rob.enq_pc = 64'h0000_0000_8000_0000; rob.enq_instr = 32'h0000_0013;
        rob.enq_lrd = 5'd1; rob.enq_prd = 6'd7; rob.enq_old_prd = 6'd3;
        check("t1_idx", rob.enq_robidx, 64'd0);
        cycle(1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
        check("t1_count", rob.count, 64'd1);
        check("t1_cv", rob.commit_valid, 64'd0);
        cycle(1'b0, 2'b01, 0, 0, 1'b0, 1'b0);
        check("t2_cv", rob.commit_valid, 64'd1);
        check("t2_old_prd", rob.commit_old_prd[PREG_W-1:0], 64'd3);
        check("t2_pc", rob.commit_pc[PC_W-1:0], 64'h8000_0000);
        cycle(1'b0, 2'b00, 0, 0, 1'b0, 1'b0);
        check("t2_count", rob.count, 64'd0);

        // Fill to full (head index 1), then one refused enqueue.
        repeat (DEPTH) cycle(1'b1, 2'b00, 0, 0, 1'b0, 1'b1);
        check("t3_ready", rob.enq_ready, 64'd0);
        check("t3_count", rob.count, 64'd16);
        cycle(1'b1, 2'b00, 0, 0, 1'b0, 1'b1);
        check("t3_idx", rob.enq_robidx, 64'd1);
        check("t3_count2", rob.count, 64'd16);

        // Younger entries complete first: nothing retires until the head does.
        cycle(1'b0, 2'b11, 2, 3, 1'b0, 1'b1);
        check("t4_cv_stall", rob.commit_valid, 64'd0);
        cycle(1'b1, 2'b01, 1, 0, 1'b0, 1'b1);
        check("t4_cv", rob.commit_valid, 64'd3);
        check("t4_ready_full", rob.enq_ready, 64'd0);
        cycle(1'b1, 2'b00, 0, 0, 1'b0, 1'b1);
        check("t4_count", rob.count, 64'd14);
        check("t4_ready", rob.enq_ready, 64'd1);

        // Wrap-around: head at 14, tail wraps to 2.
        do_reset();
        repeat (14) cycle(1'b1, 2'b00, 0, 0, 1'b0, 1'b1);
        for (int k = 0; k < 7; k++) cycle(1'b0, 2'b11, 2*k, 2*k+1, 1'b0, 1'b1);
        repeat (8) cycle(1'b0, 2'b00, 0, 0, 1'b0, 1'b1);
        check("t5_empty", rob.count, 64'd0);
        check("t5_head", rob.enq_robidx, 64'd14);
        repeat (4) cycle(1'b1, 2'b00, 0, 0, 1'b0, 1'b1);
        check("t5_tail", rob.enq_robidx, 64'd2);
        cycle(1'b0, 2'b11, 14, 15, 1'b0, 1'b1);
        check("t5_cv", rob.commit_valid, 64'd3);
        cycle(1'b0, 2'b00, 0, 0, 1'b0, 1'b1);
        check("t5_count", rob.count, 64'd2);

`ifdef ROB_FLUSH_EN
        do_reset();
        repeat (5) cycle(1'b1, 2'b00, 0, 0, 1'b0, 1'b1);
        cycle(1'b1, 2'b01, 0, 0, 1'b1, 1'b1);
        check("t6_count", rob.count, 64'd0);
        check("t6_idx", rob.enq_robidx, 64'd0);
`endif

        // Randomized traffic with one reset in the middle.
        for (int it = 0; it < 3000; it++) begin
            bit ev;
            bit fl;
            int w0;
            int w1;
            if (it == 1500) do_reset();
            ev = ($urandom % 10) < 6;
            w0 = (m_head + int'($urandom % DEPTH)) % DEPTH;
            w1 = (m_head + int'($urandom % DEPTH)) % DEPTH;
            fl = 1'b0;
`ifdef ROB_FLUSH_EN
            fl = ($urandom % 100) == 0;
`endif
            cycle(ev, 2'($urandom), w0, w1, fl, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
